// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MEM-stage data memory responder:
//   - mem_state_e : responder FSM states (IDLE / WAIT / DONE / ERR)
//   - OP_*        : primary opcode values that drive MemRead / MemWrite
//   - DATA_W_DEF  : default data word width
//   - is_misaligned() : word-alignment test on the two low address bits
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } mem_state_e;

  // Word accesses must have both byte-offset bits clear.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port synchronous word RAM, DEPTH_WORDS x DATA_W.
// The read data register only loads on i_re, so o_dout holds the last
// word read until the next read; it is the responder's rdata.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high, clears o_dout only (array kept)
//   i_we    in   write i_din into word i_idx
//   i_re    in   capture word i_idx into o_dout
//   i_idx   in   word index
//   i_din   in   write data
//   o_dout  out  registered read data
// ---------------------------------------------------------------------------
module dmem_array #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_dout;

  // Array write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_din;
    end
  end

  // Read data register, updated only when a load commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
    end else if (i_re) begin
      r_dout <= r_mem[i_idx];
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for MemRead / MemWrite from the control path.
// Accepts one word request at a time, spends WAIT_STATES cycles in WAIT,
// commits the access, then pulses mem_ready for one cycle. Illegal requests
// (both strobes, or misaligned address) pulse mem_err and touch nothing.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high
//   MemRead    in   load request
//   MemWrite   in   store request
//   addr       in   byte address (wraps modulo DEPTH_WORDS*4)
//   wdata      in   store data
//   rdata      out  last loaded word, held until the next load
//   mem_ready  out  one-cycle pulse, access complete
//   mem_stall  out  hold MEM stage and earlier (combinational in IDLE)
//   mem_err    out  one-cycle pulse, request rejected
// ---------------------------------------------------------------------------
module data_mem_responder
  import mips_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              mem_err
);

  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int CNT_RAW  = $clog2(WAIT_STATES + 1);
  localparam int CNT_W    = (CNT_RAW > 0) ? CNT_RAW : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic NO_WAIT = (WAIT_STATES == 0);

  mem_state_e        r_state;
  mem_state_e        w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_load;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready;
  logic              r_err;

  logic              w_req;
  logic              w_bad;
  logic              w_commit;
  logic              w_stall;
  logic              w_live;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_din;
  logic              w_load;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_dout;
  logic              w_unused_addr;

  assign w_req = MemRead | MemWrite;
  assign w_bad = (MemRead & MemWrite) | is_misaligned(addr[1:0]);

  // Upper address bits only select aliases of the same word.
  assign w_unused_addr = &{1'b0, addr[31:IDX_W+2]};

  // Next-state, commit strobe and stall decode.
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    w_stall  = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_req;
        if (w_req) begin
          if (w_bad) begin
            w_next = ERR;
          end else if (NO_WAIT) begin
            w_next   = DONE;
            w_commit = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_next   = DONE;
          w_commit = 1'b1;
        end else begin
          w_next = WAIT;
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A zero-wait commit happens in IDLE, before anything is latched, so the
  // array is fed from the live inputs there and from the latches otherwise.
  assign w_live = (r_state == IDLE);
  assign w_idx  = w_live ? addr[IDX_W+1:2] : r_idx;
  assign w_din  = w_live ? wdata           : r_wdata;
  assign w_load = w_live ? MemRead         : r_is_load;

  // Reset on the commit edge wins: an aborted store never reaches the array.
  assign w_we = w_commit & ~w_load & ~reset;
  assign w_re = w_commit &  w_load & ~reset;

  // FSM state, request latches and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_is_load <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_req) begin
        r_idx     <= addr[IDX_W+1:2];
        r_wdata   <= wdata;
        r_is_load <= MemRead;
        r_cnt     <= CNT_INIT;
      end else if ((r_state == WAIT) && (r_cnt != {CNT_W{1'b0}})) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Completion pulses, registered so they line up with DONE / ERR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= (w_next == DONE);
      r_err   <= (w_next == ERR);
    end
  end

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_idx  (w_idx),
    .i_din  (w_din),
    .o_dout (w_dout)
  );

  assign rdata     = w_dout;
  assign mem_ready = r_ready;
  assign mem_err   = r_err;
  assign mem_stall = w_stall;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Two responders: dut_a with two wait states, dut_b with none. Each cycle a
// transaction-level model (accept cycle + fixed latency arithmetic) predicts
// stall / ready / err / rdata and is compared against both DUTs. Directed
// sequences pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);
  localparam int WS_A  = 2;
  localparam int WS_B  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [2];
  logic          rd    [2];
  logic          wr    [2];
  logic [31:0]   ad    [2];
  logic [DW-1:0] wd    [2];
  logic [DW-1:0] rdata [2];
  logic          ready [2];
  logic          stall [2];
  logic          err   [2];

  data_mem_responder #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .reset(rst[0]), .MemRead(rd[0]), .MemWrite(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .rdata(rdata[0]), .mem_ready(ready[0]), .mem_stall(stall[0]), .mem_err(err[0]));

  data_mem_responder #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) dut_b (
    .clk(clk), .reset(rst[1]), .MemRead(rd[1]), .MemWrite(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .rdata(rdata[1]), .mem_ready(ready[1]), .mem_stall(stall[1]), .mem_err(err[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? WS_A : WS_B;
  endfunction

  // ---------------- transaction-level reference model ----------------
  int            cyc = 0;
  bit            armed      [2];
  int            busy_until [2];
  int            pulse_at   [2];
  int            commit_at  [2];
  bit            pulse_err  [2];
  bit            op_load    [2];
  int            op_idx     [2];
  logic [DW-1:0] op_data    [2];
  logic [DW-1:0] mmem       [2][DEPTH];
  bit            mknown     [2][DEPTH];
  logic [DW-1:0] m_rdata    [2];
  bit            m_rknown   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      armed[k] = 1'b0; busy_until[k] = 0; pulse_at[k] = -1; commit_at[k] = -1;
      pulse_err[k] = 1'b0; m_rdata[k] = '0; m_rknown[k] = 1'b1;
    end
  end

  // Compare DUT outputs with the model, then advance the model over the
  // coming rising edge using the (now stable) inputs.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit idle, req, e_stall, e_rdy, e_err;
      idle    = (cyc >= busy_until[k]);
      req     = rd[k] | wr[k];
      e_stall = idle ? req : (!pulse_err[k] && (cyc < pulse_at[k]));
      e_rdy   = (cyc == pulse_at[k]) && !pulse_err[k];
      e_err   = (cyc == pulse_at[k]) &&  pulse_err[k];
      if (armed[k]) begin
        chk($sformatf("k%0d c%0d stall", k, cyc), stall[k], e_stall);
        chk($sformatf("k%0d c%0d ready", k, cyc), ready[k], e_rdy);
        chk($sformatf("k%0d c%0d err",   k, cyc), err[k],   e_err);
        if (m_rknown[k]) chk($sformatf("k%0d c%0d rdata", k, cyc), rdata[k], m_rdata[k]);
      end
      if (rst[k]) begin
        armed[k] = 1'b1; busy_until[k] = cyc + 1; pulse_at[k] = -1; commit_at[k] = -1;
        m_rdata[k] = '0; m_rknown[k] = 1'b1;
      end else begin
        if (idle && req) begin
          if ((rd[k] && wr[k]) || (ad[k][1:0] != 2'b00)) begin
            pulse_err[k] = 1'b1; pulse_at[k] = cyc + 1; busy_until[k] = cyc + 2; commit_at[k] = -1;
          end else begin
            op_load[k] = rd[k]; op_idx[k] = int'(ad[k][AW+1:2]); op_data[k] = wd[k];
            pulse_err[k]  = 1'b0;
            commit_at[k]  = cyc + ws_of(k);
            pulse_at[k]   = cyc + ws_of(k) + 1;
            busy_until[k] = cyc + ws_of(k) + 2;
          end
        end
        if (commit_at[k] == cyc) begin
          if (op_load[k]) begin
            m_rdata[k]  = mmem[k][op_idx[k]];
            m_rknown[k] = mknown[k][op_idx[k]];
          end else begin
            mmem[k][op_idx[k]]   = op_data[k];
            mknown[k][op_idx[k]] = 1'b1;
          end
        end
      end
    end
    cyc++;
  end

  // One request: present it for one cycle (or hold it), optionally scramble
  // addr/wdata after acceptance, and report the cycle of the pulse.
  task automatic req(input int k, input bit r, input bit w, input logic [31:0] a,
                     input logic [DW-1:0] d, input bit scramble,
                     output int rdy_n, output int err_n, output int stall_n);
    bit done;
    rdy_n = -1; err_n = -1; stall_n = 0; done = 1'b0;
    @(posedge clk); #2;
    rd[k] = r; wr[k] = w; ad[k] = a; wd[k] = d;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (stall[k]) stall_n++;
      if (ready[k]) begin rdy_n = n; done = 1'b1; end
      if (err[k])   begin err_n = n; done = 1'b1; end
      if (!done) begin
        @(posedge clk); #2;
        rd[k] = 1'b0; wr[k] = 1'b0;
        if (scramble) begin ad[k] = $urandom; wd[k] = $urandom; end
      end
    end
    chk($sformatf("k%0d response seen", k), done, 1'b1);
  endtask

  int rn, en, sn;
  logic [31:0] a;
  bit r, w;
  int kk, sel;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; ad[k] = '0; wd[k] = '0;
    end
    repeat (3) @(posedge clk);
    #2; rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("reset rdata", rdata[0], 32'h0);
    chk("reset ready", ready[0], 1'b0);
    chk("reset err",   err[0],   1'b0);

    // Reset in the middle of a store's WAIT phase.
    req(0, 1'b0, 1'b1, 32'h10, 32'h12345678, 1'b0, rn, en, sn);
    @(posedge clk); #2; wr[0] = 1'b1; ad[0] = 32'h10; wd[0] = 32'hDEADBEEF;
    @(posedge clk); #2; wr[0] = 1'b0; rst[0] = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2; rst[0] = 1'b0;
    @(negedge clk);
    chk("rst mid-wait rdata", rdata[0], 32'h0);
    chk("rst mid-wait ready", ready[0], 1'b0);
    chk("rst mid-wait stall", stall[0], 1'b0);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rn, en, sn);
    chk("aborted store not written", rdata[0], 32'h12345678);

    // Store then load with two wait states.
    req(0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, rn, en, sn);
    chk("sw stall cycles", sn, 3);
    chk("sw ready cycle",  rn, 3);
    req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rn, en, sn);
    chk("lw ready cycle", rn, 3);
    chk("lw rdata", rdata[0], 32'hCAFEF00D);

    // Rejected requests.
    req(0, 1'b1, 1'b0, 32'h42, 32'h0, 1'b0, rn, en, sn);
    chk("misaligned err cycle", en, 1);
    chk("misaligned no ready",  rn, -1);
    chk("misaligned rdata held", rdata[0], 32'hCAFEF00D);
    req(0, 1'b1, 1'b1, 32'h40, 32'h0, 1'b0, rn, en, sn);
    chk("both strobes err cycle", en, 1);

    // Address wrap modulo DEPTH*4.
    req(0, 1'b0, 1'b1, 32'h0000_0400, 32'h11111111, 1'b0, rn, en, sn);
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, rn, en, sn);
    chk("wrap rdata", rdata[0], 32'h11111111);

    // Inputs changed during WAIT must not matter.
    req(0, 1'b0, 1'b1, 32'h80, 32'h5A5A5A5A, 1'b1, rn, en, sn);
    req(0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, rn, en, sn);
    chk("latched addr/wdata", rdata[0], 32'h5A5A5A5A);

    // Zero wait states, load held asserted back to back.
    req(1, 1'b0, 1'b1, 32'h8, 32'h00000077, 1'b0, rn, en, sn);
    chk("zw sw ready cycle", rn, 1);
    chk("zw sw stall cycles", sn, 1);
    @(posedge clk); #2; rd[1] = 1'b1; ad[1] = 32'h8;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk($sformatf("zw ready n%0d", n), ready[1], (n % 2 == 1));
      chk($sformatf("zw stall n%0d", n), stall[1], (n % 2 == 0));
      if (n % 2 == 1) chk($sformatf("zw rdata n%0d", n), rdata[1], 32'h00000077);
    end
    @(posedge clk); #2; rd[1] = 1'b0;

    // Seed a small address window on both DUTs, then random traffic.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        req(k, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, rn, en, sn);
    for (int it = 0; it < 400; it++) begin
      kk  = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      a   = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      r   = (sel == 0) || (sel >= 2 && sel <= 5);
      w   = (sel == 0) || (sel >= 6);
      if (sel == 1) begin
        r = 1'b1;
        a[1:0] = 2'($urandom_range(1, 3));
      end
      req(kk, r, w, a, $urandom, 1'($urandom_range(0, 1)), rn, en, sn);
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
